// File: rtl/adpll_pgm_regs_if.sv
// Purpose : pad-side programming bus of the ADPLL parameter register block.
// Macro   : none here (readback is controlled by ADPLL_PGM_READBACK_EN in adpll_pgm_regs.sv).
// Signals : i_program   - program strobe from pad (async to clk)
//           i_clr       - clear command from pad (async, level high)
//           i_param_sel - register index to program / read back
//           i_pgm_value - value to program
//           o_kp, o_ki, o_dco_init, o_div_n, o_tdc_off - parameter registers
//           o_pgm_ack   - one-cycle write-complete pulse
//           o_pgm_err   - sticky error flag
//           o_rb_value  - readback of the selected register
// Modports: master drives the pad inputs, slave is the register block.
interface adpll_pgm_regs_if;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned VAL_W = 5;

  logic             i_program;
  logic             i_clr;
  logic [SEL_W-1:0] i_param_sel;
  logic [VAL_W-1:0] i_pgm_value;
  logic [VAL_W-1:0] o_kp;
  logic [VAL_W-1:0] o_ki;
  logic [VAL_W-1:0] o_dco_init;
  logic [VAL_W-1:0] o_div_n;
  logic [VAL_W-1:0] o_tdc_off;
  logic             o_pgm_ack;
  logic             o_pgm_err;
  logic [VAL_W-1:0] o_rb_value;

  modport master (
    output i_program, i_clr, i_param_sel, i_pgm_value,
    input  o_kp, o_ki, o_dco_init, o_div_n, o_tdc_off, o_pgm_ack, o_pgm_err, o_rb_value
  );

  modport slave (
    input  i_program, i_clr, i_param_sel, i_pgm_value,
    output o_kp, o_ki, o_dco_init, o_div_n, o_tdc_off, o_pgm_ack, o_pgm_err, o_rb_value
  );
endinterface

// File: rtl/adpll_pgm_regs.sv
// Purpose : ADPLL parameter registers programmed from asynchronous pad strobes.
//           program/clr are double-synchronized; a three-state FSM
//           (IDLE -> WRITE -> WAIT_LOW) performs exactly one write per strobe.
// Macro   : ADPLL_PGM_READBACK_EN - when defined, o_rb_value is a registered
//           readback of the register selected by i_param_sel; otherwise 0.
// Ports   : clk   - 50 MHz sample clock
//           rst_n - asynchronous active-low reset
//           bus   - adpll_pgm_regs_if.slave (pad inputs, register outputs)
module adpll_pgm_regs (
  input logic             clk,
  input logic             rst_n,
  adpll_pgm_regs_if.slave bus
);
  localparam int unsigned SEL_W = 3;
  localparam int unsigned VAL_W = 5;

  localparam logic [VAL_W-1:0] KP_DEF  = VAL_W'(4);
  localparam logic [VAL_W-1:0] KI_DEF  = VAL_W'(1);
  localparam logic [VAL_W-1:0] DCO_DEF = VAL_W'(16);
  localparam logic [VAL_W-1:0] DIV_DEF = VAL_W'(8);
  localparam logic [VAL_W-1:0] TDC_DEF = VAL_W'(0);
  localparam logic [VAL_W-1:0] DIV_MIN = VAL_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT_LOW} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prog_meta, r_prog_s;
  logic             r_clr_meta, r_clr_s;
  logic [SEL_W-1:0] r_sel;
  logic [VAL_W-1:0] r_val;
  logic [VAL_W-1:0] r_kp, r_ki, r_dco_init, r_div_n, r_tdc_off;
  logic             r_pgm_ack, r_pgm_err;
  logic             w_capture, w_commit;

  // Two-flop synchronizers for the pad strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prog_meta <= 1'b0;
      r_prog_s    <= 1'b0;
      r_clr_meta  <= 1'b0;
      r_clr_s     <= 1'b0;
    end else begin
      r_prog_meta <= bus.i_program;
      r_prog_s    <= r_prog_meta;
      r_clr_meta  <= bus.i_clr;
      r_clr_s     <= r_clr_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; clear parks the FSM in WAIT_LOW so a held strobe cannot write
  always_comb begin
    w_state_nxt = r_state;
    if (r_clr_s) begin
      w_state_nxt = S_WAIT_LOW;
    end else begin
      unique case (r_state)
        S_IDLE:     if (r_prog_s) w_state_nxt = S_WRITE;
        S_WRITE:    w_state_nxt = S_WAIT_LOW;
        S_WAIT_LOW: if (!r_prog_s) w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: capture the request, then commit it (clear discards both)
  always_comb begin
    w_capture = 1'b0;
    w_commit  = 1'b0;
    if (!r_clr_s) begin
      w_capture = (r_state == S_IDLE) && r_prog_s;
      w_commit  = (r_state == S_WRITE);
    end
  end

  // Request capture; pads are guaranteed stable from program rise until ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
      r_val <= '0;
    end else if (w_capture) begin
      r_sel <= bus.i_param_sel;
      r_val <= bus.i_pgm_value;
    end
  end

  // Parameter registers, ack pulse and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kp       <= KP_DEF;
      r_ki       <= KI_DEF;
      r_dco_init <= DCO_DEF;
      r_div_n    <= DIV_DEF;
      r_tdc_off  <= TDC_DEF;
      r_pgm_ack  <= 1'b0;
      r_pgm_err  <= 1'b0;
    end else if (r_clr_s) begin
      r_kp       <= KP_DEF;
      r_ki       <= KI_DEF;
      r_dco_init <= DCO_DEF;
      r_div_n    <= DIV_DEF;
      r_tdc_off  <= TDC_DEF;
      r_pgm_ack  <= 1'b0;
      r_pgm_err  <= 1'b0;
    end else begin
      r_pgm_ack <= w_commit;
      if (w_commit) begin
        case (r_sel)
          SEL_W'(0): r_kp       <= r_val;
          SEL_W'(1): r_ki       <= r_val;
          SEL_W'(2): r_dco_init <= r_val;
          SEL_W'(3): begin
            // Divide ratios below 2 are illegal: clamp and flag
            if (r_val < DIV_MIN) begin
              r_div_n   <= DIV_MIN;
              r_pgm_err <= 1'b1;
            end else begin
              r_div_n   <= r_val;
            end
          end
          SEL_W'(4): r_tdc_off  <= r_val;
          default:   r_pgm_err  <= 1'b1;
        endcase
      end
    end
  end

`ifdef ADPLL_PGM_READBACK_EN
  logic [VAL_W-1:0] r_rb_value;

  // Registered readback, one cycle behind i_param_sel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb_value <= '0;
    end else begin
      case (bus.i_param_sel)
        SEL_W'(0): r_rb_value <= r_kp;
        SEL_W'(1): r_rb_value <= r_ki;
        SEL_W'(2): r_rb_value <= r_dco_init;
        SEL_W'(3): r_rb_value <= r_div_n;
        SEL_W'(4): r_rb_value <= r_tdc_off;
        default:   r_rb_value <= '0;
      endcase
    end
  end

  assign bus.o_rb_value = r_rb_value;
`else
  assign bus.o_rb_value = '0;
`endif

  assign bus.o_kp       = r_kp;
  assign bus.o_ki       = r_ki;
  assign bus.o_dco_init = r_dco_init;
  assign bus.o_div_n    = r_div_n;
  assign bus.o_tdc_off  = r_tdc_off;
  assign bus.o_pgm_ack  = r_pgm_ack;
  assign bus.o_pgm_err  = r_pgm_err;
endmodule

// File: tb/tb_adpll_pgm_regs.sv
// Purpose : scoreboard bench for adpll_pgm_regs. Each programming strobe pushes
//           its hand-computed register snapshot; a monitor pops and compares on
//           every o_pgm_ack, and flags any ack with nothing expected.
module tb_adpll_pgm_regs;
  typedef struct packed {
    logic [4:0] kp;
    logic [4:0] ki;
    logic [4:0] dco;
    logic [4:0] div;
    logic [4:0] tdc;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  exp_t sb[$];

  adpll_pgm_regs_if ifc ();

  adpll_pgm_regs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (rst_n && ifc.o_pgm_ack) begin
      a = {ifc.o_kp, ifc.o_ki, ifc.o_dco_init, ifc.o_div_n, ifc.o_tdc_off, ifc.o_pgm_err};
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ack: got ack with regs %h, expected no ack", a);
      end else begin
        e = sb.pop_front();
        if (a == e) n_pass++;
        else $display("FAIL ack_regs: got %h expected %h", a, e);
      end
    end
  end

  // Strobe program, check ack after edge N+3, hold extra cycles, release
  task automatic do_write(input logic [2:0] sel, input logic [4:0] val,
                          input exp_t e, input int hold);
    sb.push_back(e);
    @(posedge clk); #1;
    ifc.i_param_sel = sel;
    ifc.i_pgm_value = val;
    ifc.i_program   = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ack_latency", int'(ifc.o_pgm_ack), 1);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    ifc.i_program = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic check_defaults(input string tag);
    @(negedge clk);
    check({tag, "_kp"},  int'(ifc.o_kp), 4);
    check({tag, "_ki"},  int'(ifc.o_ki), 1);
    check({tag, "_dco"}, int'(ifc.o_dco_init), 16);
    check({tag, "_div"}, int'(ifc.o_div_n), 8);
    check({tag, "_tdc"}, int'(ifc.o_tdc_off), 0);
    check({tag, "_ack"}, int'(ifc.o_pgm_ack), 0);
    check({tag, "_err"}, int'(ifc.o_pgm_err), 0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    ifc.i_program = 1'b0;
    ifc.i_clr = 1'b0;
    ifc.i_param_sel = 3'd0;
    ifc.i_pgm_value = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_defaults("reset");
    check("reset_rb", int'(ifc.o_rb_value), 0);

    // kp=7, program held 20 extra cycles: only one ack
    do_write(3'd0, 5'd7, '{kp:7, ki:1, dco:16, div:8, tdc:0, err:0}, 20);

    // Readback of kp, then an unmapped index
    @(negedge clk); ifc.i_param_sel = 3'd0;
    @(posedge clk); @(negedge clk);
`ifdef ADPLL_PGM_READBACK_EN
    check("rb_kp", int'(ifc.o_rb_value), 7);
`else
    check("rb_kp", int'(ifc.o_rb_value), 0);
`endif
    ifc.i_param_sel = 3'd5;
    @(posedge clk); @(negedge clk);
    check("rb_sel5", int'(ifc.o_rb_value), 0);

    // div_n=1 clamps to 2 with error; following valid write keeps error
    do_write(3'd3, 5'd1, '{kp:7, ki:1, dco:16, div:2, tdc:0, err:1}, 0);
    do_write(3'd1, 5'd5, '{kp:7, ki:5, dco:16, div:2, tdc:0, err:1}, 0);
    // Unmapped index: no change, error, still acked
    do_write(3'd6, 5'd9, '{kp:7, ki:5, dco:16, div:2, tdc:0, err:1}, 0);
    // Legal boundary div_n and tdc writes
    do_write(3'd3, 5'd31, '{kp:7, ki:5, dco:16, div:31, tdc:0, err:1}, 0);
    do_write(3'd4, 5'd2, '{kp:7, ki:5, dco:16, div:31, tdc:2, err:1}, 0);

    // clr pulse restores defaults and clears error
    @(negedge clk); ifc.i_clr = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); ifc.i_clr = 1'b0;
    repeat (3) @(posedge clk);
    check_defaults("clr");

    // program and clr together: clear wins, no write, no ack
    @(posedge clk); #1;
    ifc.i_param_sel = 3'd2;
    ifc.i_pgm_value = 5'd3;
    ifc.i_program = 1'b1;
    ifc.i_clr = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("race_dco", int'(ifc.o_dco_init), 16);
    ifc.i_clr = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("race_held_dco", int'(ifc.o_dco_init), 16);
    ifc.i_program = 1'b0;
    repeat (5) @(posedge clk);
    do_write(3'd2, 5'd3, '{kp:4, ki:1, dco:3, div:8, tdc:0, err:0}, 0);

    // div_n=0 also clamps
    do_write(3'd3, 5'd0, '{kp:4, ki:1, dco:3, div:2, tdc:0, err:1}, 0);

    // Reset mid-write: nothing partial survives
    @(posedge clk); #1;
    ifc.i_param_sel = 3'd0;
    ifc.i_pgm_value = 5'd20;
    ifc.i_program = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    ifc.i_program = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    check_defaults("midwrite_reset");

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
